alu_op_sequencer: RTL and testbench
===================================

Name: alu_op_sequencer

Overview:
Control stage directly upstream of the 8-bit ALU built from two chained 74181 slices. Accepts an opcode plus operands over a valid/ready handshake and drives S/M/CNb and A/B to the ALU from registers. Waits a programmable settle time, then captures F and carry-out into a result register and a persistent flag register. Returns the result over a second valid/ready handshake.

Parameters:
SETTLE_CYCLES, 1, cycles between operand launch and capture; legal 1..15, elaboration error otherwise
DATA_W, 8, operand/result width (two 4-bit slices)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
req_valid  in  1  request present
req_ready  out  1  sequencer can accept
req_op  in  4  opcode: 0 ADD, 1 ADC, 2 SUB, 3 SBC, 4 AND, 5 OR, 6 XOR, 7 NOTA, 8 INC, 9 DEC, 10 PASSA, 11 CMP, 12-15 illegal
req_a  in  DATA_W  operand A
req_b  in  DATA_W  operand B
alu_a  out  DATA_W  to ALU A inputs
alu_b  out  DATA_W  to ALU B inputs
alu_s  out  4  to ALU S inputs
alu_m  out  1  to ALU M (1 = logic)
alu_cnb  out  1  to low slice CNb (active-low carry-in)
alu_f  in  DATA_W  from ALU F outputs
alu_cn4b  in  1  from high slice CN4b (active-low carry-out)
rsp_valid  out  1  result available
rsp_ready  in  1  consumer accepts
rsp_data  out  DATA_W  captured F
rsp_wr  out  1  result is to be written back (0 for CMP/illegal)
rsp_err  out  1  illegal opcode
flags  out  4  {V,N,C,Z}, persistent

Behaviour:
- Single clock clk; rst asynchronous active-high.
- Reset: state IDLE; req_ready=1 after reset; alu_a/alu_b/rsp_data=0; alu_s=4'b1111, alu_m=1 (F=A); alu_cnb=1; rsp_valid/rsp_wr/rsp_err=0; flags=0; settle counter=0.
- FSM IDLE -> SETTLE -> DONE -> IDLE. req_ready=1 only in IDLE; no request overlap.
- IDLE: on req_valid, latch A/B and decoded S/M/CNb into ALU-driving registers; load counter=SETTLE_CYCLES-1; go SETTLE.
- SETTLE: counter decrements each cycle. At the edge where counter==0, capture alu_f and alu_cn4b into rsp_data/flags, set rsp_valid, go DONE. Capture edge = acceptance edge + SETTLE_CYCLES.
- DONE: rsp_* and ALU drives held stable while rsp_valid && !rsp_ready. On handshake, clear rsp_valid and return to IDLE. A new request is accepted no earlier than the edge after the response handshake.
- Decode (active-high data), as S/M/CNb:
  - ADD 1001/0/1
  - ADC 1001/0/~C
  - SUB and CMP 0110/0/0
  - SBC 0110/0/~C
  - AND 1011/1/x
  - OR 1110/1/x
  - XOR 0110/1/x
  - NOTA 0000/1/x
  - INC 0000/0/0
  - DEC 1111/0/1
  - PASSA 1111/1/x
  - Illegal opcodes use PASSA encoding.
  - x is driven as 1.
- ADC/SBC sample the C flag at acceptance.
- Flags at capture: Z = (F==0); N = F[7]; C = ~alu_cn4b for ADD/ADC/SUB/SBC/CMP (for subtracts, C=1 means no borrow). Logic ops clear C. INC/DEC leave C unchanged.
- Illegal opcode: rsp_err=1, rsp_wr=0, all flags unchanged.
- CMP: rsp_wr=0, flags updated.
- Reset mid-SETTLE or mid-DONE: immediate return to the reset values; the pending result is discarded.

Optional Feature:
- ALU_OVERFLOW_FLAG_EN defined: V computed at capture.
  - ADD/ADC: V = (A7==B7)&&(F7!=A7)
  - SUB/SBC/CMP: V = (A7!=B7)&&(F7!=A7)
  - INC: V = (A==8'h7F)
  - DEC: V = (A==8'h80)
  - Logic ops: V cleared
  - Illegal: V unchanged
- Undefined: flags[3] tied 0, no overflow logic.

Decomposition:
- Package alu_seq_pkg: opcode enum; flag bit index constants (FLG_Z=0, FLG_C=1, FLG_N=2, FLG_V=3); S/M encoding constants per op; FSM state enum.
- Sub-module alu_op_decode: combinational opcode + C flag -> {S, M, CNb, wr, err, arith, logic_clr_c}.

Test Plan:
- Stimulus ADD 8'h7F+8'h01, SETTLE_CYCLES=1 -> rsp_valid 1 cycle after accept; rsp_data=8'h80; flags N=1, C=0, Z=0, and V=1 if ALU_OVERFLOW_FLAG_EN is defined.
- Stimulus ADD 8'hFF+8'h01, then ADC 8'h00+8'h00 -> first response 8'h00 with Z=1, C=1; ADC drives alu_cnb=0 and returns 8'h01 with C=0.
- Stimulus SUB 8'h00-8'h01 -> 8'hFF, C=0, N=1. Stimulus SUB 8'h10-8'h10 -> 8'h00, Z=1, C=1.
- Stimulus CMP 8'h05,8'h05, then opcode 4'hD -> CMP gives rsp_wr=0 with Z=1. Opcode 4'hD gives rsp_err=1 and leaves flags identical to the prior value.
- Stimulus SETTLE_CYCLES=3 with rsp_ready held low for 5 cycles -> capture 3 cycles after accept; rsp_data and alu_* stable throughout; req_ready=0 until the edge after the handshake.
- Stimulus rst pulse during SETTLE -> all outputs at reset values immediately (asynchronous); no rsp_valid afterwards; next request processed normally.

Source files
------------

// File: rtl/alu_seq_pkg.sv
// Shared types and constants for the ALU op sequencer.
// Opcodes, flag bit positions, 74181 S/M encodings and FSM states.
package alu_seq_pkg;

    typedef enum logic [3:0] {
        OP_ADD   = 4'd0,
        OP_ADC   = 4'd1,
        OP_SUB   = 4'd2,
        OP_SBC   = 4'd3,
        OP_AND   = 4'd4,
        OP_OR    = 4'd5,
        OP_XOR   = 4'd6,
        OP_NOTA  = 4'd7,
        OP_INC   = 4'd8,
        OP_DEC   = 4'd9,
        OP_PASSA = 4'd10,
        OP_CMP   = 4'd11
    } op_e;

    localparam int FLG_Z = 0;
    localparam int FLG_C = 1;
    localparam int FLG_N = 2;
    localparam int FLG_V = 3;

    // 74181 select codes, active-high data
    localparam logic [3:0] S_ADD   = 4'b1001;
    localparam logic [3:0] S_SUB   = 4'b0110;
    localparam logic [3:0] S_AND   = 4'b1011;
    localparam logic [3:0] S_OR    = 4'b1110;
    localparam logic [3:0] S_XOR   = 4'b0110;
    localparam logic [3:0] S_NOTA  = 4'b0000;
    localparam logic [3:0] S_INC   = 4'b0000;
    localparam logic [3:0] S_DEC   = 4'b1111;
    localparam logic [3:0] S_PASSA = 4'b1111;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_DONE   = 2'd2
    } state_e;

endpackage

// File: rtl/alu_op_decode.sv
// Opcode decoder: opcode + current C flag -> 74181 S/M/CNb and result class.
// Ports: op, c in; s, m, cnb, wr, err, arith, logic_clr_c out.
module alu_op_decode
    import alu_seq_pkg::*;
(
    input  logic [3:0] op,
    input  logic       c,
    output logic [3:0] s,
    output logic       m,
    output logic       cnb,
    output logic       wr,
    output logic       err,
    output logic       arith,
    output logic       logic_clr_c
);

    always_comb begin
        s           = S_PASSA;
        m           = 1'b1;
        cnb         = 1'b1;
        wr          = 1'b1;
        err         = 1'b0;
        arith       = 1'b0;
        logic_clr_c = 1'b1;
        unique case (1'b1)
            (op == OP_ADD): begin
                s = S_ADD; m = 1'b0;
                arith = 1'b1; logic_clr_c = 1'b0;
            end
            (op == OP_ADC): begin
                s = S_ADD; m = 1'b0; cnb = ~c;
                arith = 1'b1; logic_clr_c = 1'b0;
            end
            (op == OP_SUB): begin
                s = S_SUB; m = 1'b0; cnb = 1'b0;
                arith = 1'b1; logic_clr_c = 1'b0;
            end
            (op == OP_CMP): begin
                s = S_SUB; m = 1'b0; cnb = 1'b0; wr = 1'b0;
                arith = 1'b1; logic_clr_c = 1'b0;
            end
            (op == OP_SBC): begin
                s = S_SUB; m = 1'b0; cnb = ~c;
                arith = 1'b1; logic_clr_c = 1'b0;
            end
            (op == OP_AND):   s = S_AND;
            (op == OP_OR):    s = S_OR;
            (op == OP_XOR):   s = S_XOR;
            (op == OP_NOTA):  s = S_NOTA;
            (op == OP_PASSA): s = S_PASSA;
            // INC/DEC go through the adder but leave C alone
            (op == OP_INC): begin
                s = S_INC; m = 1'b0; cnb = 1'b0;
                logic_clr_c = 1'b0;
            end
            (op == OP_DEC): begin
                s = S_DEC; m = 1'b0;
                logic_clr_c = 1'b0;
            end
            default: begin
                wr = 1'b0; err = 1'b1;
                logic_clr_c = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/alu_op_sequencer.sv
// Request/settle/capture sequencer in front of a 2x74181 ALU.
// Ports: req_* in (valid/ready), alu_* drives out, alu_f/alu_cn4b back,
// rsp_* out (valid/ready), flags {V,N,C,Z}.
// Define ALU_OVERFLOW_FLAG_EN to compute V; otherwise flags[3] is 0.
module alu_op_sequencer
    import alu_seq_pkg::*;
#(
    parameter int SETTLE_CYCLES = 1,
    parameter int DATA_W        = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [3:0]        req_op,
    input  logic [DATA_W-1:0] req_a,
    input  logic [DATA_W-1:0] req_b,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [3:0]        alu_s,
    output logic              alu_m,
    output logic              alu_cnb,
    input  logic [DATA_W-1:0] alu_f,
    input  logic              alu_cn4b,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_wr,
    output logic              rsp_err,
    output logic [3:0]        flags
);

    if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 15) begin : g_bad_settle
        $error("SETTLE_CYCLES must be in 1..15");
    end

    localparam logic [3:0] CNT_INIT = 4'(SETTLE_CYCLES - 1);

    state_e     state;
    logic [3:0] cnt;
    logic       arith_q;
    logic       clr_c_q;
    logic       wr_q;
    logic       err_q;
    logic [3:0] dec_s;
    logic       dec_m;
    logic       dec_cnb;
    logic       dec_wr;
    logic       dec_err;
    logic       dec_arith;
    logic       dec_clr_c;
    logic [3:0] flags_cap;

    alu_op_decode u_dec (
        .op          (req_op),
        .c           (flags[FLG_C]),
        .s           (dec_s),
        .m           (dec_m),
        .cnb         (dec_cnb),
        .wr          (dec_wr),
        .err         (dec_err),
        .arith       (dec_arith),
        .logic_clr_c (dec_clr_c)
    );

`ifdef ALU_OVERFLOW_FLAG_EN
    localparam logic [DATA_W-1:0] MAX_POS = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic [DATA_W-1:0] MIN_NEG = {1'b1, {(DATA_W-1){1'b0}}};

    logic [3:0] op_q;
    logic       ovf;
    logic       a7;
    logic       b7;
    logic       f7;

    always_comb begin
        a7  = alu_a[DATA_W-1];
        b7  = alu_b[DATA_W-1];
        f7  = alu_f[DATA_W-1];
        ovf = 1'b0;
        unique case (1'b1)
            (op_q == OP_ADD) || (op_q == OP_ADC):
                ovf = (a7 == b7) && (f7 != a7);
            (op_q == OP_SUB) || (op_q == OP_SBC) || (op_q == OP_CMP):
                ovf = (a7 != b7) && (f7 != a7);
            (op_q == OP_INC): ovf = (alu_a == MAX_POS);
            (op_q == OP_DEC): ovf = (alu_a == MIN_NEG);
            default:          ovf = 1'b0;
        endcase
    end
`endif

    // Flag value written at the capture edge
    always_comb begin
        flags_cap = flags;
        if (!err_q) begin
            flags_cap[FLG_Z] = (alu_f == '0);
            flags_cap[FLG_N] = alu_f[DATA_W-1];
            if (arith_q)
                flags_cap[FLG_C] = ~alu_cn4b;
            else if (clr_c_q)
                flags_cap[FLG_C] = 1'b0;
`ifdef ALU_OVERFLOW_FLAG_EN
            flags_cap[FLG_V] = ovf;
`endif
        end
`ifndef ALU_OVERFLOW_FLAG_EN
        flags_cap[FLG_V] = 1'b0;
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            cnt       <= 4'd0;
            req_ready <= 1'b1;
            alu_a     <= '0;
            alu_b     <= '0;
            alu_s     <= S_PASSA;
            alu_m     <= 1'b1;
            alu_cnb   <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_wr    <= 1'b0;
            rsp_err   <= 1'b0;
            flags     <= 4'd0;
            arith_q   <= 1'b0;
            clr_c_q   <= 1'b0;
            wr_q      <= 1'b0;
            err_q     <= 1'b0;
`ifdef ALU_OVERFLOW_FLAG_EN
            op_q      <= 4'd0;
`endif
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        alu_a     <= req_a;
                        alu_b     <= req_b;
                        alu_s     <= dec_s;
                        alu_m     <= dec_m;
                        alu_cnb   <= dec_cnb;
                        arith_q   <= dec_arith;
                        clr_c_q   <= dec_clr_c;
                        wr_q      <= dec_wr;
                        err_q     <= dec_err;
`ifdef ALU_OVERFLOW_FLAG_EN
                        op_q      <= req_op;
`endif
                        cnt       <= CNT_INIT;
                        req_ready <= 1'b0;
                        state     <= ST_SETTLE;
                    end
                end
                ST_SETTLE: begin
                    if (cnt == 4'd0) begin
                        rsp_data  <= alu_f;
                        flags     <= flags_cap;
                        rsp_wr    <= wr_q;
                        rsp_err   <= err_q;
                        rsp_valid <= 1'b1;
                        state     <= ST_DONE;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                ST_DONE: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        req_ready <= 1'b1;
                        state     <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer: 74181-style ALU model, vector table,
// plus settle/stall and asynchronous reset sequences.
module tb_alu_op_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;

    // instance with SETTLE_CYCLES=1
    logic       req_valid = 1'b0;
    logic       req_ready;
    logic [3:0] req_op = 4'd0;
    logic [7:0] req_a = 8'd0;
    logic [7:0] req_b = 8'd0;
    logic [7:0] alu_a, alu_b, alu_f, rsp_data;
    logic [3:0] alu_s, flags;
    logic       alu_m, alu_cnb, alu_cn4b;
    logic       rsp_valid, rsp_wr, rsp_err;
    logic       rsp_ready = 1'b0;

    // instance with SETTLE_CYCLES=3
    logic       req_valid3 = 1'b0;
    logic       req_ready3;
    logic [3:0] req_op3 = 4'd0;
    logic [7:0] req_a3 = 8'd0;
    logic [7:0] req_b3 = 8'd0;
    logic [7:0] alu_a3, alu_b3, alu_f3, rsp_data3;
    logic [3:0] alu_s3, flags3;
    logic       alu_m3, alu_cnb3, alu_cn4b3;
    logic       rsp_valid3, rsp_wr3, rsp_err3;
    logic       rsp_ready3 = 1'b0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // Active-high 74181 pair: returns {cn4b, f}
    function automatic logic [8:0] alu181(
        input logic [7:0] a, input logic [7:0] b,
        input logic [3:0] s, input logic m, input logic cnb);
        logic [7:0] f;
        logic [7:0] x;
        logic [8:0] sum;
        if (m) begin
            case (s)
                4'b1011: f = a & b;
                4'b1110: f = a | b;
                4'b0110: f = a ^ b;
                4'b0000: f = ~a;
                4'b1111: f = a;
                default: f = 8'h00;
            endcase
            return {1'b1, f};
        end
        case (s)
            4'b1001: x = b;
            4'b0110: x = ~b;
            4'b0000: x = 8'h00;
            4'b1111: x = 8'hFF;
            default: x = 8'h00;
        endcase
        sum = {1'b0, a} + {1'b0, x} + {8'd0, ~cnb};
        return {~sum[8], sum[7:0]};
    endfunction

    assign {alu_cn4b, alu_f} = alu181(alu_a, alu_b, alu_s, alu_m, alu_cnb);
    assign {alu_cn4b3, alu_f3} =
        alu181(alu_a3, alu_b3, alu_s3, alu_m3, alu_cnb3);

    alu_op_sequencer #(.SETTLE_CYCLES(1), .DATA_W(8)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_a(req_a), .req_b(req_b),
        .alu_a(alu_a), .alu_b(alu_b), .alu_s(alu_s),
        .alu_m(alu_m), .alu_cnb(alu_cnb),
        .alu_f(alu_f), .alu_cn4b(alu_cn4b),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_wr(rsp_wr), .rsp_err(rsp_err),
        .flags(flags)
    );

    alu_op_sequencer #(.SETTLE_CYCLES(3), .DATA_W(8)) dut3 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid3), .req_ready(req_ready3),
        .req_op(req_op3), .req_a(req_a3), .req_b(req_b3),
        .alu_a(alu_a3), .alu_b(alu_b3), .alu_s(alu_s3),
        .alu_m(alu_m3), .alu_cnb(alu_cnb3),
        .alu_f(alu_f3), .alu_cn4b(alu_cn4b3),
        .rsp_valid(rsp_valid3), .rsp_ready(rsp_ready3),
        .rsp_data(rsp_data3), .rsp_wr(rsp_wr3), .rsp_err(rsp_err3),
        .flags(flags3)
    );

    task automatic chk(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", name, act, exp);
        end
    endtask

    // ncz = {N,C,Z}; v is the overflow bit when that flag is built in
    typedef struct {
        logic [3:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] f;
        logic       wr;
        logic       err;
        logic [2:0] ncz;
        logic       v;
        logic       cnb;
    } vec_t;

    vec_t vecs[22];

    function automatic logic [3:0] exp_flags(input logic v,
                                             input logic [2:0] ncz);
`ifdef ALU_OVERFLOW_FLAG_EN
        return {v, ncz};
`else
        return {1'b0, ncz};
`endif
    endfunction

    task automatic run_vec(input int i);
        vec_t v;
        int   w;
        int   lat;
        logic cnb_seen;
        v = vecs[i];
        @(negedge clk);
        req_op = v.op; req_a = v.a; req_b = v.b; req_valid = 1'b1;
        w = 0;
        while (!req_ready && w < 20) begin
            @(negedge clk);
            w++;
        end
        chk($sformatf("v%0d ready", i), {31'd0, req_ready}, 32'd1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        cnb_seen = alu_cnb;
        lat = 0;
        do begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end while (!rsp_valid && lat < 20);
        chk($sformatf("v%0d lat", i), lat, 32'd1);
        chk($sformatf("v%0d data", i), {24'd0, rsp_data}, {24'd0, v.f});
        chk($sformatf("v%0d wr", i), {31'd0, rsp_wr}, {31'd0, v.wr});
        chk($sformatf("v%0d err", i), {31'd0, rsp_err}, {31'd0, v.err});
        chk($sformatf("v%0d flags", i), {28'd0, flags},
            {28'd0, exp_flags(v.v, v.ncz)});
        chk($sformatf("v%0d cnb", i), {31'd0, cnb_seen}, {31'd0, v.cnb});
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
    endtask

    initial begin
        int   lat;
        logic seen;
        //             op     a      b      f      wr    err   ncz     v     cnb
        vecs[0]  = '{4'd0,  8'h7F, 8'h01, 8'h80, 1'b1, 1'b0, 3'b100, 1'b1, 1'b1};
        vecs[1]  = '{4'd0,  8'hFF, 8'h01, 8'h00, 1'b1, 1'b0, 3'b011, 1'b0, 1'b1};
        vecs[2]  = '{4'd1,  8'h00, 8'h00, 8'h01, 1'b1, 1'b0, 3'b000, 1'b0, 1'b0};
        vecs[3]  = '{4'd2,  8'h00, 8'h01, 8'hFF, 1'b1, 1'b0, 3'b100, 1'b0, 1'b0};
        vecs[4]  = '{4'd2,  8'h10, 8'h10, 8'h00, 1'b1, 1'b0, 3'b011, 1'b0, 1'b0};
        vecs[5]  = '{4'd11, 8'h05, 8'h05, 8'h00, 1'b0, 1'b0, 3'b011, 1'b0, 1'b0};
        vecs[6]  = '{4'd13, 8'h33, 8'h44, 8'h33, 1'b0, 1'b1, 3'b011, 1'b0, 1'b1};
        vecs[7]  = '{4'd4,  8'hF0, 8'h3C, 8'h30, 1'b1, 1'b0, 3'b000, 1'b0, 1'b1};
        vecs[8]  = '{4'd5,  8'h80, 8'h01, 8'h81, 1'b1, 1'b0, 3'b100, 1'b0, 1'b1};
        vecs[9]  = '{4'd6,  8'hFF, 8'h0F, 8'hF0, 1'b1, 1'b0, 3'b100, 1'b0, 1'b1};
        vecs[10] = '{4'd7,  8'hFF, 8'h00, 8'h00, 1'b1, 1'b0, 3'b001, 1'b0, 1'b1};
        vecs[11] = '{4'd8,  8'h7F, 8'h00, 8'h80, 1'b1, 1'b0, 3'b100, 1'b1, 1'b0};
        vecs[12] = '{4'd0,  8'h80, 8'h80, 8'h00, 1'b1, 1'b0, 3'b011, 1'b1, 1'b1};
        vecs[13] = '{4'd9,  8'h00, 8'h00, 8'hFF, 1'b1, 1'b0, 3'b110, 1'b0, 1'b1};
        vecs[14] = '{4'd3,  8'h10, 8'h05, 8'h0B, 1'b1, 1'b0, 3'b010, 1'b0, 1'b0};
        vecs[15] = '{4'd2,  8'h01, 8'h02, 8'hFF, 1'b1, 1'b0, 3'b100, 1'b0, 1'b0};
        vecs[16] = '{4'd3,  8'h10, 8'h05, 8'h0A, 1'b1, 1'b0, 3'b010, 1'b0, 1'b1};
        vecs[17] = '{4'd9,  8'h80, 8'h00, 8'h7F, 1'b1, 1'b0, 3'b010, 1'b1, 1'b1};
        vecs[18] = '{4'd10, 8'h5A, 8'h00, 8'h5A, 1'b1, 1'b0, 3'b000, 1'b0, 1'b1};
        vecs[19] = '{4'd15, 8'h00, 8'h00, 8'h00, 1'b0, 1'b1, 3'b000, 1'b0, 1'b1};
        vecs[20] = '{4'd8,  8'hFF, 8'h00, 8'h00, 1'b1, 1'b0, 3'b001, 1'b0, 1'b0};
        vecs[21] = '{4'd2,  8'h80, 8'h01, 8'h7F, 1'b1, 1'b0, 3'b010, 1'b1, 1'b0};

        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst ready", {31'd0, req_ready}, 32'd1);
        chk("rst alu_a", {24'd0, alu_a}, 32'h0);
        chk("rst alu_b", {24'd0, alu_b}, 32'h0);
        chk("rst alu_s", {28'd0, alu_s}, 32'hF);
        chk("rst alu_m", {31'd0, alu_m}, 32'd1);
        chk("rst cnb", {31'd0, alu_cnb}, 32'd1);
        chk("rst valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst data", {24'd0, rsp_data}, 32'h0);
        chk("rst wr", {31'd0, rsp_wr}, 32'd0);
        chk("rst err", {31'd0, rsp_err}, 32'd0);
        chk("rst flags", {28'd0, flags}, 32'h0);

        for (int i = 0; i < 22; i++) run_vec(i);

        // SETTLE_CYCLES=3 with a 5-cycle consumer stall
        @(negedge clk);
        req_op3 = 4'd0; req_a3 = 8'h80; req_b3 = 8'h90; req_valid3 = 1'b1;
        @(posedge clk);
        #1;
        req_valid3 = 1'b0;
        lat = 0;
        do begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end while (!rsp_valid3 && lat < 20);
        chk("s3 lat", lat, 32'd3);
        // next request waits while the response is stalled
        req_op3 = 4'd2; req_a3 = 8'h01; req_b3 = 8'h02; req_valid3 = 1'b1;
        for (int k = 0; k < 5; k++) begin
            chk("s3 valid", {31'd0, rsp_valid3}, 32'd1);
            chk("s3 data", {24'd0, rsp_data3}, 32'h10);
            chk("s3 alu_a", {24'd0, alu_a3}, 32'h80);
            chk("s3 alu_b", {24'd0, alu_b3}, 32'h90);
            chk("s3 alu_s", {28'd0, alu_s3}, 32'h9);
            chk("s3 ready", {31'd0, req_ready3}, 32'd0);
            @(negedge clk);
        end
        rsp_ready3 = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready3 = 1'b0;
        chk("s3 ready lo", {31'd0, req_ready3}, 32'd1);
        @(negedge clk);
        chk("s3 hs valid", {31'd0, rsp_valid3}, 32'd0);
        chk("s3 alu_a hs", {24'd0, alu_a3}, 32'h80);
        chk("s3 flags", {28'd0, flags3}, {28'd0, exp_flags(1'b1, 3'b010)});
        @(posedge clk);
        #1;
        req_valid3 = 1'b0;
        chk("s3 acc2", {31'd0, req_ready3}, 32'd0);
        chk("s3 acc2 a", {24'd0, alu_a3}, 32'h01);

        // asynchronous reset in the middle of SETTLE
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("ar ready", {31'd0, req_ready3}, 32'd1);
        chk("ar alu_a", {24'd0, alu_a3}, 32'h0);
        chk("ar alu_b", {24'd0, alu_b3}, 32'h0);
        chk("ar alu_s", {28'd0, alu_s3}, 32'hF);
        chk("ar alu_m", {31'd0, alu_m3}, 32'd1);
        chk("ar cnb", {31'd0, alu_cnb3}, 32'd1);
        chk("ar flags", {28'd0, flags3}, 32'h0);
        chk("ar data", {24'd0, rsp_data3}, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        seen = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (rsp_valid3) seen = 1'b1;
        end
        chk("ar no rsp", {31'd0, seen}, 32'd0);

        req_op3 = 4'd0; req_a3 = 8'h7F; req_b3 = 8'h01; req_valid3 = 1'b1;
        @(posedge clk);
        #1;
        req_valid3 = 1'b0;
        lat = 0;
        do begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end while (!rsp_valid3 && lat < 20);
        chk("ar2 lat", lat, 32'd3);
        chk("ar2 data", {24'd0, rsp_data3}, 32'h80);
        chk("ar2 flags", {28'd0, flags3}, {28'd0, exp_flags(1'b1, 3'b100)});
        rsp_ready3 = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready3 = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
